// File: rtl/nvdla_glb_gec_csb_bridge.sv
// CSB-to-GEC request bridge: in-order request FIFO, outstanding-response tracking,
// unexpected-response drop. Optional response timeout: define GLB_GEC_RESP_TIMEOUT_EN.
module nvdla_glb_gec_csb_bridge #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned MAX_OUTST   = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic        csb_req_pvld,
  output logic        csb_req_prdy,
  input  logic [62:0] csb_req_pd,
  output logic        gec_req_pvld,
  input  logic        gec_req_prdy,
  output logic [62:0] gec_req_pd,
  input  logic        gec_resp_valid,
  input  logic [33:0] gec_resp_pd,
  output logic        csb_resp_valid,
  output logic [33:0] csb_resp_pd,
  output logic        unexp_resp,
  output logic        timeout_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [62:0]          r_fifo [DEPTH];
  logic [DEPTH-1:0]     r_fexp;
  logic [AW-1:0]        r_wp;
  logic [AW-1:0]        r_rp;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_pend;
  logic [2:0]           r_outst;
  logic [MAX_OUTST-1:0] r_tq;
  logic                 r_resp_valid;
  logic [33:0]          r_resp_pd;
  logic                 r_unexp;
  logic                 r_timeout;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_push_exp;
  logic                 w_issue;
  logic                 w_resp;
  logic                 w_drop;
  logic                 w_to;
  logic                 w_deq;
  logic [3:0]           w_sum;
  logic [2:0]           w_tq_wi;
  logic [MAX_OUTST-1:0] w_tq_nxt;

  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_push_exp = ~csb_req_pd[54] | csb_req_pd[55];
  assign w_sum      = {1'b0, r_outst} + {1'b0, r_pend};

  // Ready counts both issued and still-queued response-expecting requests,
  // so the type queue can never overflow.
  assign csb_req_prdy = nvdla_core_rstn & ~w_full & (w_sum < 4'(MAX_OUTST));
  assign w_push       = csb_req_pvld & csb_req_prdy;

  assign gec_req_pvld = ~w_empty;
  assign gec_req_pd   = r_fifo[r_rp];
  assign w_pop        = ~w_empty & gec_req_prdy;
  assign w_issue      = w_pop & r_fexp[r_rp];

  assign w_resp = gec_resp_valid & (r_outst != '0);
  assign w_drop = gec_resp_valid & (r_outst == '0);
  assign w_deq  = w_resp | w_to;

`ifdef GLB_GEC_RESP_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);
  logic [7:0] r_timer;

  assign w_to = (r_outst != '0) & ~gec_resp_valid & (r_timer == TO_LIMIT);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      r_timer <= '0;
    else if ((r_outst == '0) || gec_resp_valid || w_to)
      r_timer <= '0;
    else
      r_timer <= r_timer + 8'd1;
  end
`else
  assign w_to = 1'b0;
`endif

  // Type queue is a shift register whose occupancy equals r_outst; head at bit 0.
  assign w_tq_wi = w_deq ? (r_outst - 3'd1) : r_outst;

  always_comb begin
    w_tq_nxt = r_tq;
    if (w_deq)
      w_tq_nxt = r_tq >> 1;
    for (int unsigned i = 0; i < MAX_OUTST; i++) begin
      if (w_issue && (3'(i) == w_tq_wi))
        w_tq_nxt[i] = gec_req_pd[54];
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (w_push)
      r_fifo[r_wp] <= csb_req_pd;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_fexp       <= '0;
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_pend       <= '0;
      r_outst      <= '0;
      r_tq         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_pd    <= '0;
      r_unexp      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fexp[r_wp] <= w_push_exp;
        r_wp         <= r_wp + AW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      case ({w_push & w_push_exp, w_issue})
        2'b10:   r_pend <= r_pend + 3'd1;
        2'b01:   r_pend <= r_pend - 3'd1;
        default: r_pend <= r_pend;
      endcase

      case ({w_issue, w_deq})
        2'b10:   r_outst <= r_outst + 3'd1;
        2'b01:   r_outst <= r_outst - 3'd1;
        default: r_outst <= r_outst;
      endcase

      r_tq         <= w_tq_nxt;
      r_resp_valid <= w_deq;
      if (w_deq)
        r_resp_pd <= w_to ? {r_tq[0], 1'b1, 32'h0} : gec_resp_pd;
      r_unexp      <= w_drop;
      r_timeout    <= w_to;
    end
  end

  assign csb_resp_valid = r_resp_valid;
  assign csb_resp_pd    = r_resp_pd;
  assign unexp_resp     = r_unexp;
  assign timeout_err    = r_timeout;

endmodule

// File: tb/tb_nvdla_glb_gec_csb_bridge.sv
// Directed self-checking bench for nvdla_glb_gec_csb_bridge (DEPTH=2, MAX_OUTST=2, TIMEOUT_CYC=8).
module tb_nvdla_glb_gec_csb_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        csb_req_pvld;
  logic        csb_req_prdy;
  logic [62:0] csb_req_pd;
  logic        gec_req_pvld;
  logic        gec_req_prdy;
  logic [62:0] gec_req_pd;
  logic        gec_resp_valid;
  logic [33:0] gec_resp_pd;
  logic        csb_resp_valid;
  logic [33:0] csb_resp_pd;
  logic        unexp_resp;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  nvdla_glb_gec_csb_bridge #(
    .DEPTH      (2),
    .MAX_OUTST  (2),
    .TIMEOUT_CYC(8)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .csb_req_pvld   (csb_req_pvld),
    .csb_req_prdy   (csb_req_prdy),
    .csb_req_pd     (csb_req_pd),
    .gec_req_pvld   (gec_req_pvld),
    .gec_req_prdy   (gec_req_prdy),
    .gec_req_pd     (gec_req_pd),
    .gec_resp_valid (gec_resp_valid),
    .gec_resp_pd    (gec_resp_pd),
    .csb_resp_valid (csb_resp_valid),
    .csb_resp_pd    (csb_resp_pd),
    .unexp_resp     (unexp_resp),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [62:0] mk_req(input logic [21:0] addr, input logic [31:0] wdat,
                                         input logic wr, input logic np);
    return {2'b00, 4'hF, 1'b0, np, wr, wdat, addr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [62:0] w1, w2, rq;
  int          found;
  int          seen_to;

  initial begin
    rstn = 1'b0; csb_req_pvld = 1'b0; csb_req_pd = '0;
    gec_req_prdy = 1'b0; gec_resp_valid = 1'b0; gec_resp_pd = '0;
    tick(); tick();
    chk("rst_prdy",   64'(csb_req_prdy),   64'd0);
    chk("rst_gvld",   64'(gec_req_pvld),   64'd0);
    chk("rst_rvld",   64'(csb_resp_valid), 64'd0);
    chk("rst_rpd",    64'(csb_resp_pd),    64'd0);
    chk("rst_unexp",  64'(unexp_resp),     64'd0);
    chk("rst_tmo",    64'(timeout_err),    64'd0);
    rstn = 1'b1;
    #1;
    chk("rel_prdy",   64'(csb_req_prdy),   64'd1);

    // Single read, response one cycle after issue
    gec_req_prdy = 1'b1;
    rq = mk_req(22'h1234, 32'h0, 1'b0, 1'b0);
    csb_req_pvld = 1'b1; csb_req_pd = rq;
    tick();
    csb_req_pvld = 1'b0;
    chk("rd_gvld",    64'(gec_req_pvld),   64'd1);
    chk("rd_gpd",     64'(gec_req_pd),     64'(rq));
    tick();
    chk("rd_gvld0",   64'(gec_req_pvld),   64'd0);
    gec_resp_valid = 1'b1; gec_resp_pd = {1'b0, 1'b0, 32'hDEADBEEF};
    tick();
    gec_resp_valid = 1'b0;
    chk("rd_rvld",    64'(csb_resp_valid), 64'd1);
    chk("rd_rpd",     64'(csb_resp_pd),    64'h0DEADBEEF);
    tick();
    chk("rd_rvld0",   64'(csb_resp_valid), 64'd0);

    // Posted write: forwarded, then a stray response shows nothing is outstanding
    rq = mk_req(22'h0055, 32'hCAFEF00D, 1'b1, 1'b0);
    csb_req_pvld = 1'b1; csb_req_pd = rq;
    tick();
    csb_req_pvld = 1'b0;
    chk("pw_gpd",     64'(gec_req_pd),     64'(rq));
    tick(); tick();
    chk("pw_norsp",   64'(csb_resp_valid), 64'd0);
    gec_resp_valid = 1'b1; gec_resp_pd = 34'h1_2345_6789;
    tick();
    gec_resp_valid = 1'b0;
    chk("ux_pulse",   64'(unexp_resp),     64'd1);
    chk("ux_rvld",    64'(csb_resp_valid), 64'd0);
    tick();
    chk("ux_clear",   64'(unexp_resp),     64'd0);

    // Three back-to-back reads against MAX_OUTST=2 with GEC silent
    csb_req_pvld = 1'b1; csb_req_pd = mk_req(22'h0100, 32'h0, 1'b0, 1'b0);
    tick();
    csb_req_pd = mk_req(22'h0104, 32'h0, 1'b0, 1'b0);
    chk("bb_prdy2",   64'(csb_req_prdy),   64'd1);
    tick();
    csb_req_pd = mk_req(22'h0108, 32'h0, 1'b0, 1'b0);
    chk("bb_stall",   64'(csb_req_prdy),   64'd0);
    tick();
    chk("bb_stall2",  64'(csb_req_prdy),   64'd0);
    gec_resp_valid = 1'b1; gec_resp_pd = 34'h0_1111_0000;
    tick();
    gec_resp_valid = 1'b0;
    chk("bb_r1vld",   64'(csb_resp_valid), 64'd1);
    chk("bb_r1pd",    64'(csb_resp_pd),    64'h0_1111_0000);
    chk("bb_reopen",  64'(csb_req_prdy),   64'd1);
    tick();
    csb_req_pvld = 1'b0;
    // Third read issues in the same cycle as a response arrives
    gec_resp_valid = 1'b1; gec_resp_pd = 34'h1_2222_0000;
    tick();
    gec_resp_pd = 34'h0_3333_0000;
    chk("bb_r2pd",    64'(csb_resp_pd),    64'h1_2222_0000);
    tick();
    gec_resp_valid = 1'b0;
    chk("bb_r3vld",   64'(csb_resp_valid), 64'd1);
    chk("bb_r3pd",    64'(csb_resp_pd),    64'h0_3333_0000);
    tick();
    chk("bb_r3end",   64'(csb_resp_valid), 64'd0);
    chk("bb_idle",    64'(csb_req_prdy),   64'd1);

    // Backpressure: two posted writes fill the FIFO while GEC is not ready
    gec_req_prdy = 1'b0;
    w1 = mk_req(22'h0200, 32'hA5A5A5A5, 1'b1, 1'b0);
    w2 = mk_req(22'h0204, 32'h5A5A5A5A, 1'b1, 1'b0);
    csb_req_pvld = 1'b1; csb_req_pd = w1;
    tick();
    csb_req_pd = w2;
    tick();
    csb_req_pvld = 1'b0;
    chk("bp_full",    64'(csb_req_prdy),   64'd0);
    tick(); tick();
    chk("bp_hold",    64'(gec_req_pd),     64'(w1));
    gec_req_prdy = 1'b1;
    tick();
    chk("bp_w2vld",   64'(gec_req_pvld),   64'd1);
    chk("bp_w2pd",    64'(gec_req_pd),     64'(w2));
    tick();
    chk("bp_empty",   64'(gec_req_pvld),   64'd0);
    chk("bp_prdy",    64'(csb_req_prdy),   64'd1);

    // Non-posted write left unanswered
    csb_req_pvld = 1'b1; csb_req_pd = mk_req(22'h0300, 32'h0000_0001, 1'b1, 1'b1);
    tick();
    csb_req_pvld = 1'b0;
    tick();
    found = 0; seen_to = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) seen_to = 1;
      if (csb_resp_valid) begin
        found = 1;
        break;
      end
      tick();
    end
`ifdef GLB_GEC_RESP_TIMEOUT_EN
    chk("to_found",   64'(found),          64'd1);
    chk("to_pd",      64'(csb_resp_pd),    64'h3_0000_0000);
    chk("to_err",     64'(timeout_err),    64'd1);
    tick();
    chk("to_end",     64'(timeout_err),    64'd0);
`else
    chk("nto_found",  64'(found),          64'd0);
    chk("nto_err",    64'(seen_to),        64'd0);
`endif

    // Reset with a read outstanding and a write still queued
    gec_req_prdy = 1'b1;
    csb_req_pvld = 1'b1; csb_req_pd = mk_req(22'h0400, 32'h0, 1'b0, 1'b0);
    tick();
    csb_req_pvld = 1'b0;
    tick();
    gec_req_prdy = 1'b0;
    csb_req_pvld = 1'b1; csb_req_pd = mk_req(22'h0404, 32'h77, 1'b1, 1'b0);
    tick();
    csb_req_pvld = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mr_prdy",    64'(csb_req_prdy),   64'd0);
    chk("mr_gvld",    64'(gec_req_pvld),   64'd0);
    chk("mr_rpd",     64'(csb_resp_pd),    64'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("mr_relprdy", 64'(csb_req_prdy),   64'd1);
    chk("mr_relgvld", 64'(gec_req_pvld),   64'd0);
    gec_resp_valid = 1'b1; gec_resp_pd = 34'h0_0000_0042;
    tick();
    gec_resp_valid = 1'b0;
    chk("mr_unexp",   64'(unexp_resp),     64'd1);
    chk("mr_rvld",    64'(csb_resp_valid), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nvdla_glb_gec_csb_bridge.md
NVDLA_GLB_GEC_CSB_BRIDGE -- requirements
Module: nvdla_glb_gec_csb_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 2: request FIFO entries; legal values 2 or 4.
REQ-002 SHALL have parameter MAX_OUTST, default 2: maximum number of responses outstanding; legal range 1..4.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: response timeout in cycles; 8-bit, legal range 1..255.
REQ-004 SHALL have port nvdla_core_clk, input, 1 bit: core clock.
REQ-005 SHALL have port nvdla_core_rstn, input, 1 bit: reset; asynchronous, active-low; all logic is clocked by nvdla_core_clk.
REQ-006 SHALL have port csb_req_pvld, input, 1 bit: upstream CSB request valid.
REQ-007 SHALL have port csb_req_prdy, output, 1 bit: upstream CSB request ready.
REQ-008 SHALL have port csb_req_pd, input, 63 bits: request payload, fields as follows.
- addr[21:0]
- wdat[53:22]
- write[54]
- nposted[55]
- srcpriv[56]
- wrbe[60:57]
- level[62:61]
REQ-009 SHALL have port gec_req_pvld, output, 1 bit: request valid toward the GEC slave.
REQ-010 SHALL have port gec_req_prdy, input, 1 bit: GEC slave ready.
REQ-011 SHALL have port gec_req_pd, output, 63 bits: request payload toward GEC, same format as csb_req_pd.
REQ-012 SHALL have port gec_resp_valid, input, 1 bit: GEC response strobe.
REQ-013 SHALL have port gec_resp_pd, input, 34 bits: GEC response, fields as follows.
- rdat[31:0]
- error[32]
- id[33]: 0 = read, 1 = write
REQ-014 SHALL have port csb_resp_valid, output, 1 bit: upstream response strobe.
REQ-015 SHALL have port csb_resp_pd, output, 34 bits: upstream response, same format as gec_resp_pd.
REQ-016 SHALL have port unexp_resp, output, 1 bit: one-cycle pulse when a response is dropped.
REQ-017 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a timeout response is synthesized.

Function
REQ-018 SHALL buffer requests in a DEPTH-entry FIFO that drains in order: gec_req_pvld = FIFO non-empty, and gec_req_pd = FIFO head.
REQ-019 SHALL drive csb_req_prdy = !full & (outst_cnt + pending_expect < MAX_OUTST), where pending_expect is the number of response-expecting entries held in the FIFO.
REQ-020 SHALL accept a request into the FIFO only when csb_req_pvld & csb_req_prdy; push and pop in the same cycle are both honoured, leaving the count unchanged.
REQ-021 SHALL classify a request as expecting a response when it is a read (write = 0) or a non-posted write (write = 1 & nposted = 1); posted writes expect no response.
REQ-022 SHALL, on a GEC handshake of a response-expecting request, increment outst_cnt and push its id (write bit) onto an MAX_OUTST-entry type queue.
REQ-023 SHALL, on gec_resp_valid with outst_cnt > 0, register csb_resp_valid = 1 and csb_resp_pd = gec_resp_pd on the next cycle, decrement outst_cnt, and pop the type queue.
REQ-024 SHALL, on gec_resp_valid with outst_cnt = 0, drop the response, keep csb_resp_valid = 0, and pulse unexp_resp one cycle later.
REQ-025 SHALL leave outst_cnt unchanged when an issue and a response occur in the same cycle, while the type queue pushes and pops correctly.
REQ-026 SHALL never assert csb_resp_valid in two consecutive cycles unless gec_resp_valid did.

Reset
REQ-027 SHALL, while nvdla_core_rstn is low, hold the following values.
- FIFO empty
- outst_cnt = 0
- type queue empty
- timer = 0
- csb_req_prdy = 0
- gec_req_pvld = 0
- csb_resp_valid = 0
- csb_resp_pd = 0
- unexp_resp = 0
- timeout_err = 0
REQ-028 SHALL, when reset is asserted mid-transaction, discard all queued and outstanding state without emitting any response; csb_req_prdy rises in the first cycle after deassertion.

Configuration
REQ-029 SHALL, when GLB_GEC_RESP_TIMEOUT_EN is defined, run an 8-bit timer while outst_cnt > 0.
- The timer clears on any gec_resp_valid.
- When the timer reaches TIMEOUT_CYC with no response in that cycle, the block emits csb_resp_valid = 1 with csb_resp_pd = {type-queue head, 1'b1, 32'h0} on the next cycle, pulses timeout_err, decrements outst_cnt, pops the type queue, and clears the timer.
REQ-030 SHALL, when GLB_GEC_RESP_TIMEOUT_EN is undefined, tie timeout_err to 0, instantiate no timer, and allow outst_cnt to remain non-zero indefinitely.

Verification
REQ-031 SHALL cover a read at addr 0x1234 with GEC returning rdat 0xDEADBEEF one cycle later -> csb_resp_pd = {0, 0, 0xDEADBEEF} one cycle after gec_resp_valid, and outst_cnt returns to 0.
REQ-032 SHALL cover a posted write (write = 1, nposted = 0) -> forwarded to GEC, no csb_resp_valid, and outst_cnt stays 0.
REQ-033 SHALL cover 3 back-to-back reads with GEC silent and MAX_OUTST = 2 -> csb_req_prdy = 0 after 2 accepts, and it reasserts the cycle after the first response.
REQ-034 SHALL cover gec_req_prdy held low for 4 cycles with 2 posted writes pushed -> FIFO full, csb_req_prdy = 0, and no payload lost after release.
REQ-035 SHALL cover gec_resp_valid asserted with outst_cnt = 0 -> unexp_resp pulses for 1 cycle and csb_resp_valid stays 0.
REQ-036 SHALL cover, with GLB_GEC_RESP_TIMEOUT_EN defined and TIMEOUT_CYC = 8, a non-posted write left unanswered -> csb_resp_pd = {1, 1, 0} with timeout_err; with the macro undefined -> no response is emitted.
